// File: rtl/util_rst_seq_if.sv
// Sideband bundle between the reset sequencer and its consumers.
// sw_rst exists only when UTIL_RST_SEQ_SW_RST_EN is defined.
interface util_rst_seq_if #(
   parameter int NUM_STAGES = 3
);
   logic                  locked;
   logic [NUM_STAGES-1:0] rst_out_n;
   logic                  seq_done;
`ifdef UTIL_RST_SEQ_SW_RST_EN
   logic                  sw_rst;
`endif

   modport master (
`ifdef UTIL_RST_SEQ_SW_RST_EN
      input  sw_rst,
`endif
      input  locked,
      output rst_out_n,
      output seq_done
   );

   modport slave (
`ifdef UTIL_RST_SEQ_SW_RST_EN
      output sw_rst,
`endif
      output locked,
      input  rst_out_n,
      input  seq_done
   );
endinterface

// File: rtl/util_rst_seq.sv
// Reset sequencer: holds all stages for MIN_ASSERT cycles, waits for a synchronised lock,
// then releases stages in index order every STAGE_DLY cycles. UTIL_RST_SEQ_SW_RST_EN adds sw_rst.
module util_rst_seq #(
   parameter int NUM_STAGES   = 3,
   parameter int MIN_ASSERT   = 16,
   parameter int STAGE_DLY    = 8,
   parameter int LOCK_SYNC_FF = 2
) (
   input  logic         clk,
   input  logic         rstn,
   util_rst_seq_if.master bus
);
   localparam int CMAX = (MIN_ASSERT > STAGE_DLY) ? MIN_ASSERT : STAGE_DLY;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int IW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_ASSERT - 1);
   localparam logic [CW-1:0] REL_LAST  = CW'(STAGE_DLY - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

   typedef enum logic [1:0] {HOLD, WAIT_LOCK, RELEASE, DONE} state_e;

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [NUM_STAGES-1:0]   rst_q, rst_d;
   logic                    done_q, done_d;
   logic [LOCK_SYNC_FF-1:0] sync_q;
   logic                    locked_s;
   logic                    sw_rst_w;
   logic                    restart;

   assign locked_s = sync_q[LOCK_SYNC_FF-1];

`ifdef UTIL_RST_SEQ_SW_RST_EN
   assign sw_rst_w = bus.sw_rst;
`else
   assign sw_rst_w = 1'b0;
`endif

   // Software restart and loss of lock share one full-restart path; sw_rst wins by construction.
   assign restart = sw_rst_w || (((state_q == RELEASE) || (state_q == DONE)) && !locked_s);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '0;
         done_q  <= 1'b0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
         sync_q  <= {sync_q[LOCK_SYNC_FF-2:0], bus.locked};
      end
   end

   always_comb begin
      state_d = state_q;
      if (restart) begin
         state_d = HOLD;
      end else begin
         case (state_q)
            HOLD:      if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: if (locked_s) state_d = RELEASE;
            RELEASE:   if ((cnt_q == REL_LAST) && (idx_q == IDX_LAST)) state_d = DONE;
            DONE:      state_d = DONE;
            default:   state_d = HOLD;
         endcase
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      rst_d  = rst_q;
      done_d = done_q;
      if (restart) begin
         cnt_d  = '0;
         idx_d  = '0;
         rst_d  = '0;
         done_d = 1'b0;
      end else begin
         case (state_q)
            HOLD: cnt_d = (cnt_q == HOLD_LAST) ? '0 : cnt_q + 1'b1;
            WAIT_LOCK: begin
               if (locked_s) begin
                  cnt_d = '0;
                  idx_d = '0;
               end
            end
            RELEASE: begin
               if (cnt_q == REL_LAST) begin
                  cnt_d        = '0;
                  rst_d[idx_q] = 1'b1;
                  if (idx_q == IDX_LAST) done_d = 1'b1;
                  else                   idx_d  = idx_q + 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rst_out_n = rst_q;
   assign bus.seq_done  = done_q;
endmodule
